// File: rtl/reglk_ctrl.sv
// Register-lock bank controller: provisioning window, frozen set-only mode and
// JTAG debug unlock with hold qualification. Writes use a 2-cycle valid/ready handshake.
module reglk_ctrl #(
  parameter int unsigned NUM_WORDS    = 6,
  parameter int unsigned WORD_W       = 32,
  parameter int unsigned UNLOCK_DELAY = 16,
  localparam int unsigned IdxW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        soft_rst_i,
  input  logic                        boot_done_i,
  input  logic                        jtag_unlock_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [IdxW-1:0]             req_idx_i,
  input  logic [WORD_W-1:0]           req_data_i,
  input  logic                        req_priv_i,
  output logic                        resp_valid_o,
  output logic                        resp_err_o,
  output logic                        violation_o,
  output logic [1:0]                  state_o,
  output logic [NUM_WORDS*WORD_W-1:0] reglk_o
);

  localparam int unsigned CntW = $clog2(UNLOCK_DELAY + 1);
  localparam logic [IdxW:0] NumWordsW = (IdxW + 1)'(NUM_WORDS);
  localparam logic [CntW-1:0] CntLast = CntW'(UNLOCK_DELAY - 1);

  typedef enum logic [1:0] {
    StProv       = 2'd0,
    StFrozen     = 2'd1,
    StUnlockWait = 2'd2,
    StDebug      = 2'd3
  } state_e;

  state_e            state_q, state_d;
  state_e            origin_q, origin_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0] bank_q [NUM_WORDS];
  logic [WORD_W-1:0] bank_d [NUM_WORDS];
  logic              ready_q, ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic              viol_q, viol_d;

  logic              accept, idx_ok, covers, bulk_clear, bulk_set, wr_en;
  logic [CntW-1:0]   cnt_inc;
  logic [WORD_W-1:0] cur_word;
  state_e            rules;

  always_comb begin
    state_d      = state_q;
    origin_d     = origin_q;
    cnt_d        = cnt_q;
    ready_d      = ready_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    viol_d       = 1'b0;
    bulk_clear   = 1'b0;
    bulk_set     = 1'b0;
    wr_en        = 1'b0;
    cnt_inc      = cnt_q + CntW'(1);

    accept = req_valid_i & ready_q;
    idx_ok = {1'b0, req_idx_i} < NumWordsW;
    // Unlock qualification borrows the write rules of the state it came from.
    rules  = (state_q == StUnlockWait) ? origin_q : state_q;

    cur_word = '0;
    for (int j = 0; j < int'(NUM_WORDS); j++) begin
      if (req_idx_i == IdxW'(j)) cur_word = bank_q[j];
    end
    covers = (req_data_i & cur_word) == cur_word;

    unique case (state_q)
      StProv: begin
        if (boot_done_i) begin
          state_d = StFrozen;
        end else if (jtag_unlock_i) begin
          state_d  = StUnlockWait;
          origin_d = StProv;
          cnt_d    = '0;
        end
      end
      StFrozen: begin
        if (jtag_unlock_i) begin
          state_d  = StUnlockWait;
          origin_d = StFrozen;
          cnt_d    = '0;
        end
      end
      StUnlockWait: begin
        if (!jtag_unlock_i) begin
          state_d = origin_q;
          cnt_d   = '0;
        end else if (cnt_inc == CntLast) begin
          state_d    = StDebug;
          cnt_d      = '0;
          bulk_clear = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StDebug: begin
        if (!jtag_unlock_i) begin
          state_d  = StFrozen;
          bulk_set = 1'b1;
        end
      end
      default: state_d = StProv;
    endcase

    if (accept) begin
      resp_valid_d = 1'b1;
      ready_d      = 1'b0;
      resp_err_d   = 1'b1;
      // A bulk clear/set on this edge overrides the write.
      if (!bulk_clear && !bulk_set && idx_ok && req_priv_i) begin
        if (rules == StFrozen) begin
          if (covers) begin
            wr_en      = 1'b1;
            resp_err_d = 1'b0;
          end else begin
            viol_d = 1'b1;
          end
        end else begin
          wr_en      = 1'b1;
          resp_err_d = 1'b0;
        end
      end
    end else begin
      ready_d = 1'b1;
    end

    for (int j = 0; j < int'(NUM_WORDS); j++) begin
      if (bulk_clear) begin
        bank_d[j] = '0;
      end else if (bulk_set) begin
        bank_d[j] = '1;
      end else if (wr_en && (req_idx_i == IdxW'(j))) begin
        bank_d[j] = req_data_i;
      end else begin
        bank_d[j] = bank_q[j];
      end
    end

    if (soft_rst_i) begin
      state_d      = StProv;
      origin_d     = StProv;
      cnt_d        = '0;
      ready_d      = 1'b1;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      viol_d       = 1'b0;
      for (int j = 0; j < int'(NUM_WORDS); j++) bank_d[j] = '1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StProv;
      origin_q     <= StProv;
      cnt_q        <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      viol_q       <= 1'b0;
      for (int j = 0; j < int'(NUM_WORDS); j++) bank_q[j] <= '1;
    end else begin
      state_q      <= state_d;
      origin_q     <= origin_d;
      cnt_q        <= cnt_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      viol_q       <= viol_d;
      for (int j = 0; j < int'(NUM_WORDS); j++) bank_q[j] <= bank_d[j];
    end
  end

  always_comb begin
    reglk_o = '0;
    for (int j = 0; j < int'(NUM_WORDS); j++) reglk_o[j*WORD_W +: WORD_W] = bank_q[j];
  end

  assign req_ready_o  = ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign violation_o  = viol_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_reglk_ctrl.sv
// Directed self-checking bench for reglk_ctrl.
module tb_reglk_ctrl;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          soft_rst = 1'b0;
  logic          boot_done = 1'b0;
  logic          jtag = 1'b0;
  logic          valid = 1'b0;
  logic          ready;
  logic [2:0]    idx = '0;
  logic [31:0]   data = '0;
  logic          priv = 1'b0;
  logic          resp_valid, resp_err, viol;
  logic [1:0]    state;
  logic [191:0]  reglk;

  int checks = 0;
  int failures = 0;
  int pulses;

  reglk_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .soft_rst_i   (soft_rst),
    .boot_done_i  (boot_done),
    .jtag_unlock_i(jtag),
    .req_valid_i  (valid),
    .req_ready_o  (ready),
    .req_idx_i    (idx),
    .req_data_i   (data),
    .req_priv_i   (priv),
    .resp_valid_o (resp_valid),
    .resp_err_o   (resp_err),
    .violation_o  (viol),
    .state_o      (state),
    .reglk_o      (reglk)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input int j);
    return reglk[j*32 +: 32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] exp);
    for (int j = 0; j < 6; j++) chk(tag, 64'(word(j)), 64'(exp));
  endtask

  task automatic do_write(input string tag, input logic [2:0] i, input logic [31:0] d,
                          input logic p, input logic exp_err, input logic exp_viol);
    valid = 1'b1;
    idx   = i;
    data  = d;
    priv  = p;
    tick();
    valid = 1'b0;
    chk({tag, "_resp"}, 64'(resp_valid), 64'd1);
    chk({tag, "_rdy0"}, 64'(ready), 64'd0);
    chk({tag, "_err"}, 64'(resp_err), 64'(exp_err));
    chk({tag, "_viol"}, 64'(viol), 64'(exp_viol));
    tick();
    chk({tag, "_resp_end"}, 64'(resp_valid), 64'd0);
    chk({tag, "_rdy1"}, 64'(ready), 64'd1);
  endtask

  initial begin
    // 1: reset
    #23 rst = 1'b0;
    tick();
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_resp", 64'(resp_valid), 64'd0);
    chk("rst_viol", 64'(viol), 64'd0);
    chk_all("rst_bank", 32'hFFFF_FFFF);

    // 2: provisioning write, then freeze
    do_write("prov_wr", 3'd2, 32'h0000_00F0, 1'b1, 1'b0, 1'b0);
    chk("prov_w2", 64'(word(2)), 64'h0000_00F0);
    chk("prov_w0", 64'(word(0)), 64'hFFFF_FFFF);
    boot_done = 1'b1;
    tick();
    boot_done = 1'b0;
    chk("frozen_state", 64'(state), 64'd1);

    // 3: frozen set-only
    do_write("frz_set", 3'd2, 32'h0000_00F1, 1'b1, 1'b0, 1'b0);
    chk("frz_w2_f1", 64'(word(2)), 64'h0000_00F1);
    do_write("frz_clr", 3'd2, 32'h0000_0001, 1'b1, 1'b1, 1'b1);
    chk("frz_w2_kept", 64'(word(2)), 64'h0000_00F1);
    boot_done = 1'b1;
    tick();
    boot_done = 1'b0;
    chk("frz_boot_ign", 64'(state), 64'd1);

    // 4: unlock qualification
    jtag = 1'b1;
    repeat (15) tick();
    chk("wait15_state", 64'(state), 64'd2);
    jtag = 1'b0;
    tick();
    chk("wait_abort", 64'(state), 64'd1);
    chk("wait_abort_w2", 64'(word(2)), 64'h0000_00F1);
    jtag = 1'b1;
    repeat (15) tick();
    chk("wait_again", 64'(state), 64'd2);
    tick();
    chk("debug_state", 64'(state), 64'd3);
    chk_all("debug_clear", 32'h0);
    do_write("dbg_wr", 3'd1, 32'h0000_ABCD, 1'b1, 1'b0, 1'b0);
    chk("dbg_w1", 64'(word(1)), 64'h0000_ABCD);
    do_write("dbg_np", 3'd1, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    chk("dbg_np_w1", 64'(word(1)), 64'h0000_ABCD);
    // write coinciding with debug exit: bulk set wins
    valid = 1'b1;
    idx   = 3'd1;
    data  = 32'h1234_5678;
    priv  = 1'b1;
    jtag  = 1'b0;
    tick();
    valid = 1'b0;
    chk("exit_state", 64'(state), 64'd1);
    chk("exit_resp", 64'(resp_valid), 64'd1);
    chk("exit_err", 64'(resp_err), 64'd1);
    chk_all("exit_bank", 32'hFFFF_FFFF);
    tick();

    // 5: error checks in PROV
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    chk("srst_state", 64'(state), 64'd0);
    do_write("np_wr", 3'd3, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("np_w3", 64'(word(3)), 64'hFFFF_FFFF);
    do_write("idx6", 3'd6, 32'h0, 1'b1, 1'b1, 1'b0);
    do_write("idx7", 3'd7, 32'h0, 1'b1, 1'b1, 1'b0);
    chk_all("badidx_bank", 32'hFFFF_FFFF);

    // 6: back-to-back requests, then soft reset mid-request
    pulses = 0;
    valid = 1'b1;
    idx   = 3'd0;
    data  = 32'h0000_0055;
    priv  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (resp_valid) pulses++;
    end
    chk("b2b_pulses", 64'(pulses), 64'd3);
    chk("b2b_w0", 64'(word(0)), 64'h0000_0055);
    chk("b2b_rdy", 64'(ready), 64'd1);
    data     = 32'h0;
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    valid    = 1'b0;
    chk("srst_noresp", 64'(resp_valid), 64'd0);
    chk("srst_rdy", 64'(ready), 64'd1);
    chk("srst_state2", 64'(state), 64'd0);
    chk_all("srst_bank", 32'hFFFF_FFFF);
    tick();
    chk("srst_noresp2", 64'(resp_valid), 64'd0);

    // boot_done and jtag together in PROV: freeze first, qualify next cycle
    boot_done = 1'b1;
    jtag      = 1'b1;
    tick();
    boot_done = 1'b0;
    chk("sim_frozen", 64'(state), 64'd1);
    tick();
    chk("sim_wait", 64'(state), 64'd2);
    do_write("wait_frz_clr", 3'd4, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("wait_frz_w4", 64'(word(4)), 64'hFFFF_FFFF);
    jtag = 1'b0;
    tick();
    chk("sim_origin", 64'(state), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
